// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps the PC and drives a req/ack instruction-memory handshake.
// Returned words are captured into IF/ID, or into a one-entry skid buffer
// when ID is stalled. A taken-branch redirect flushes IF/ID and retargets
// the PC. A request still in flight at the moment of a redirect is drained
// in KILL, with its address held stable, and its data is discarded.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  ifid_op,
    output logic [5:0]  ifid_funct
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_KILL  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;

    logic [31:0] redirect_tgt_s;
    logic [31:0] pc_plus4_s;

    // Branch targets are word aligned; the sum wraps modulo 2^32.
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4_s     = pc_q + 32'd4;

    // Next-state, PC, skid buffer and IF/ID register update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_addr_d  = kill_addr_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_pc4_d   = ifid_pc4_q;
        // A flush beats a stall. When ID is free and nothing is loaded, the
        // register empties. Otherwise the stall freezes it.
        if (redirect || !stall) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else begin
            ifid_valid_d = ifid_valid_q;
            ifid_instr_d = ifid_instr_q;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect) begin
                    pc_d = redirect_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    pc_d = redirect_tgt_s;
                    if (!imem_ack) begin
                        // The outstanding request must still be drained.
                        kill_addr_d = pc_q;
                        state_d     = S_KILL;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4_s;
                    if (stall && ifid_valid_q) begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4_s;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = pc_plus4_s;
                        state_d      = S_FETCH;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_KILL: begin
                if (redirect) begin
                    pc_d = redirect_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_KILL;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d         = redirect_tgt_s;
                    skid_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end else if (!stall) begin
                    ifid_valid_d = skid_valid_q;
                    ifid_instr_d = skid_instr_q;
                    ifid_pc4_d   = skid_pc4_q;
                    skid_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            kill_addr_q  <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_addr_q  <= kill_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // The request decodes straight from the state register, so a zero-wait
    // ack can arrive in the first cycle the request is high.
    assign imem_req   = (state_q == S_FETCH) || (state_q == S_KILL);
    assign imem_addr  = (state_q == S_KILL) ? kill_addr_q : pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_op    = ifid_instr_q[31:26];
    assign ifid_funct = ifid_instr_q[5:0];

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage. Inputs are driven on the
// falling edge, and outputs are sampled on the falling edge that follows.
module tb_if_id_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  ifid_op;
    logic [5:0]  ifid_funct;

    int checks   = 0;
    int failures = 0;

    if_id_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_op     (ifid_op),
        .ifid_funct  (ifid_funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    vec_t vecs[13];
    sb_t  sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_ifid(input string nm, input logic v, input logic [31:0] ins, input logic [31:0] p4);
        logic [31:0] e;
        e = ins;
        chk({nm, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
        chk({nm, "_instr"}, ifid_instr, ins);
        chk({nm, "_pc4"},   ifid_pc4, p4);
        chk({nm, "_op"},    {26'd0, ifid_op}, {26'd0, e[31:26]});
        chk({nm, "_funct"}, {26'd0, ifid_funct}, {26'd0, e[5:0]});
    endtask

    task automatic chk_req(input string nm, input logic r, input logic [31:0] a);
        chk({nm, "_req"},  {31'd0, imem_req}, {31'd0, r});
        chk({nm, "_addr"}, imem_addr, a);
    endtask

    // Drive one cycle of inputs, then advance to the next falling edge.
    task automatic apply(input logic s, input logic r, input logic [31:0] rp,
                         input logic a, input logic [31:0] d);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_ack    = a;
        imem_rdata  = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setv(input int i, input logic s, input logic r, input logic [31:0] rp, input logic a,
                        input logic er, input logic [31:0] ea, input logic ev,
                        input logic [31:0] ei, input logic [31:0] ep);
        vecs[i].stall = s;  vecs[i].redir = r;  vecs[i].rpc = rp;  vecs[i].ack = a;
        vecs[i].exp_req = er; vecs[i].exp_addr = ea; vecs[i].exp_valid = ev;
        vecs[i].exp_instr = ei; vecs[i].exp_pc4 = ep;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] d;
        sb_t         e;

        // Zero-wait memory returns the address as data. The table covers
        // reset release, the stall/skid path, and flush beating stall with
        // an unaligned target.
        //      stall redir rpc           ack  req  addr          valid instr         pc4
        setv(0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000);
        setv(1,  1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000);
        setv(2,  1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0004);
        setv(3,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0008);
        setv(4,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h0000_0008);
        setv(5,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h0000_0008);
        setv(6,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'h0000_0008);
        setv(7,  1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0000_000C);
        setv(8,  1'b1, 1'b1, 32'h103,      1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0000_0010);
        setv(9,  1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0010);
        setv(10, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0010);
        setv(11, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0000_0104);
        setv(12, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 32'h0000_0104);

        do_reset();
        // Reset release happens on this falling edge.
        chk_req("reset", 1'b0, 32'h0);
        chk_ifid("reset", 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 13; i++) begin
            chk_req($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
            chk_ifid($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc4);
            apply(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].exp_addr);
        end

        // Redirect near the top of memory, then stream through the wrap.
        // The zero-wait ack taken along with the redirect is dropped.
        apply(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hAAAA_AAAA);
        exp_addr = 32'hFFFF_FFF8;
        for (int i = 0; i < 6; i++) begin
            chk_req($sformatf("wrap%0d", i), 1'b1, exp_addr);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk_ifid($sformatf("wrap%0d", i), 1'b1, e.instr, e.pc4);
            end else begin
                chk($sformatf("wrap%0d_valid", i), {31'd0, ifid_valid}, 32'd0);
            end
            d = $urandom;
            sbq.push_back('{instr: d, pc4: exp_addr + 32'd4});
            apply(1'b0, 1'b0, 32'h0, 1'b1, d);
            exp_addr = exp_addr + 32'd4;
        end
        e = sbq.pop_front();
        chk_ifid("wrap_last", 1'b1, e.instr, e.pc4);

        // Three-cycle memory, with a redirect while the request for 0x10 is
        // still outstanding.
        do_reset();
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        apply(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
        chk_req("lat_c2", 1'b1, 32'h10);
        apply(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        chk_req("lat_c3", 1'b1, 32'h10);
        chk("lat_c3_valid", {31'd0, ifid_valid}, 32'd0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_req("lat_c4", 1'b1, 32'h10);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk_req("lat_c5", 1'b1, 32'h100);
        chk_ifid("lat_c5", 1'b0, 32'h0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        chk_ifid("lat_c6", 1'b1, 32'h1234_5678, 32'h104);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_req("lat_c7", 1'b1, 32'h104);
        chk_ifid("lat_c7", 1'b1, 32'h1234_5678, 32'h104);

        // Asynchronous reset while a request waits, away from any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_req("arst", 1'b0, 32'h0);
        chk_ifid("arst", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // A stray ack in IDLE must be ignored.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0BAD);
        chk_req("arst_c1", 1'b1, 32'h0);
        chk_ifid("arst_c1", 1'b0, 32'h0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0055);
        chk_ifid("arst_c2", 1'b1, 32'h55, 32'h4);
        chk_req("arst_c2", 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register, directly upstream of the main decoder and ALU control. Holds the PC and issues requests to a variable-latency instruction memory over a req/ack handshake. Captures returned instructions into the IF/ID register and presents opcode (instr[31:26]) and funct (instr[5:0]) to the decoder. Honours a stall from the hazard unit and a taken-branch redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, IF/ID instruction value when the register is empty or flushed

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  32  word-aligned fetch address; stable while imem_req is high
imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
stall  in  1  hazard unit: ID cannot accept; IF/ID holds its contents
redirect  in  1  taken branch (Branch & Zero) from EX
redirect_pc  in  32  branch target; bits [1:0] ignored and forced to 00
ifid_valid  out  1  IF/ID holds a live instruction
ifid_instr  out  32  captured instruction
ifid_pc4  out  32  fetch PC + 4 of the captured instruction
ifid_op  out  6  ifid_instr[31:26], to decoder
ifid_funct  out  6  ifid_instr[5:0], to ALU control

Behaviour:
- Reset (async, any time): pc=RESET_PC; state IDLE; imem_req=0; imem_addr=RESET_PC; ifid_valid=0; ifid_instr=NOP_INSTR; ifid_pc4=0; skid buffer empty. Any in-flight ack is abandoned.
- States: IDLE, FETCH, KILL, HOLD.
- IDLE: exactly one cycle after rst deasserts, imem_req=0; then go to FETCH. Acks received in IDLE are ignored.
- FETCH: imem_req=1, imem_addr=pc. Zero-wait ack, in the same cycle req rises, is legal.
  - ack & ~redirect & (~stall | ~ifid_valid): IF/ID <= {rdata, pc+4}; ifid_valid<=1; pc<=pc+4; stay in FETCH. Throughput is 1 instr/cycle with zero-wait memory.
  - ack & ~redirect & stall & ifid_valid: skid <= {rdata, pc+4}; pc<=pc+4; go to HOLD.
  - ~ack & redirect: latch the outstanding address into kill_addr; pc<=redirect_pc; go to KILL.
  - ack & redirect: discard rdata; pc<=redirect_pc; stay in FETCH. The next request uses the target.
- KILL: imem_req=1, imem_addr=kill_addr, unchanged from the original request. On ack, discard rdata and go to FETCH. A further redirect in KILL updates pc only.
- HOLD: imem_req=0. When ~stall, IF/ID <= skid; ifid_valid=1; go to FETCH. When redirect, clear the skid buffer and go to FETCH.
- IF/ID update rules, applied every cycle:
  - redirect has priority over stall. ifid_valid<=0 and ifid_instr<=NOP_INSTR, unless the same-cycle ack path loads the register; that cannot occur because ack data is discarded on redirect.
  - When ~stall and nothing new is loaded, ifid_valid<=0 and ifid_instr<=NOP_INSTR.
  - When stall and no redirect, all ifid_* outputs hold.
- Latency: an instruction is visible on ifid_* the cycle after its ack.
- Arithmetic: pc+4 wraps modulo 2^32. 32'hFFFF_FFFC is followed by 32'h0000_0000.
- ifid_op and ifid_funct are combinational slices of ifid_instr.
- Stall in FETCH without ack has no effect on the request.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> imem_addr 0,4,8 on consecutive cycles; ifid_instr 0,4,8 one cycle after each ack; ifid_pc4 4,8,12; first req is the 2nd cycle after rst falls.
- Stall held 3 cycles with ifid_valid=1 and ack of instr at addr 8 -> IF/ID holds the addr-4 instr; state HOLD; imem_req=0; after stall drops, ifid_instr=8 and fetch resumes at 12.
- 3-cycle-latency memory, redirect to 32'h100 while the request for 0x10 is outstanding -> imem_addr stays 0x10 until ack; that data is dropped; the next request is 0x100; ifid_valid=0 in between.
- redirect and ack in the same cycle with stall=1 -> ifid_valid=0 next cycle (flush beats stall); the next request is at redirect_pc; redirect_pc=32'h103 is fetched as 32'h100.
- PC at 32'hFFFF_FFFC -> after ack the next imem_addr is 0, and ifid_pc4=0.
- rst pulsed mid-WAIT (req high, no ack) -> outputs return to reset values immediately; a late ack arriving in IDLE is ignored; fetch restarts at RESET_PC.
